// File: rtl/des_key_schedule_if.sv
// DES key-schedule port bundle.
//   master: drives the key, the direction and the start request; observes the schedule.
//   slave : the key-schedule engine.
// Key_Schedule_Key_Input : 64-bit key. FIPS bit n sits at index 65-n.
// Key_Schedule_Decrypt   : 0 = K1..K16 order, 1 = K16..K1 order.
// Key_Schedule_Start     : start request.
// Key_Schedule_Output    : CnDn (C = [56:29], D = [28:1]), zero when Select is low.
// Key_Schedule_Select    : Output valid.
// Key_Schedule_Round     : index 0..15 of the presented round.
// Key_Schedule_Busy      : schedule in progress.
// Key_Schedule_Finish_Flag : one-cycle pulse after the last round.
interface des_key_schedule_if;
  logic [64:1] Key_Schedule_Key_Input;
  logic        Key_Schedule_Decrypt;
  logic        Key_Schedule_Start;
  logic [56:1] Key_Schedule_Output;
  logic        Key_Schedule_Select;
  logic [3:0]  Key_Schedule_Round;
  logic        Key_Schedule_Busy;
  logic        Key_Schedule_Finish_Flag;

  modport master (
    output Key_Schedule_Key_Input, Key_Schedule_Decrypt, Key_Schedule_Start,
    input  Key_Schedule_Output, Key_Schedule_Select, Key_Schedule_Round,
    input  Key_Schedule_Busy, Key_Schedule_Finish_Flag
  );

  modport slave (
    input  Key_Schedule_Key_Input, Key_Schedule_Decrypt, Key_Schedule_Start,
    output Key_Schedule_Output, Key_Schedule_Select, Key_Schedule_Round,
    output Key_Schedule_Busy, Key_Schedule_Finish_Flag
  );
endinterface

// File: rtl/des_key_schedule.sv
// DES round key-schedule generator. Applies PC-1 to the key, then presents one 56-bit CnDn
// per cycle for 16 cycles in encrypt (C1D1..C16D16) or decrypt (C16D16..C1D1) order.
// Ports:
//   clk : rising-edge clock.
//   rst : synchronous active-high reset.
//   ks  : des_key_schedule_if.slave bundle (key, direction, start in; schedule out).
// All outputs are registered, so they trail the state register by one cycle.
module des_key_schedule #(
  parameter bit          PC1_BYPASS = 1'b0,
  parameter int unsigned ROUNDS     = 16
) (
  input  logic            clk,
  input  logic            rst,
  des_key_schedule_if.slave ks
);

  typedef enum logic [1:0] {StIdle, StLoad, StRound, StDone} state_e;

  localparam logic [3:0] LastRound = 4'(ROUNDS - 1);

  // FIPS 46-3 PC-1: output bit j (1 = MSB of C) takes key bit Pc1Tab[j-1].
  localparam int Pc1Tab [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  function automatic logic [56:1] pc1(input logic [64:1] key);
    logic [56:1] r;
    r = '0;
    for (int j = 1; j <= 56; j++) begin
      r[57-j] = key[65-Pc1Tab[j-1]];
    end
    return r;
  endfunction

  // Shift amount for schedule step idx (0-based). Decrypt starts with no rotate because
  // C0D0 already equals C16D16; its later amounts coincide with the encrypt table.
  function automatic logic [1:0] shift_amt(input logic [3:0] idx, input logic right);
    logic [1:0] a;
    if (idx == 4'd0 || idx == 4'd1 || idx == 4'd8 || idx == 4'd15) a = 2'd1;
    else                                                            a = 2'd2;
    if (right && idx == 4'd0) a = 2'd0;
    return a;
  endfunction

  function automatic logic [28:1] rot28(input logic [28:1] x, input logic [1:0] amt,
                                        input logic right);
    logic [28:1] r;
    case ({right, amt})
      3'b001:  r = {x[27:1], x[28]};
      3'b010:  r = {x[26:1], x[28:27]};
      3'b101:  r = {x[1], x[28:2]};
      3'b110:  r = {x[2:1], x[28:3]};
      default: r = x;
    endcase
    return r;
  endfunction

  // C and D rotate independently; nothing crosses the [29]/[28] boundary.
  function automatic logic [56:1] rot_cd(input logic [56:1] cd, input logic [1:0] amt,
                                         input logic right);
    return {rot28(cd[56:29], amt, right), rot28(cd[28:1], amt, right)};
  endfunction

  state_e      state_q, state_d;
  logic [56:1] cd_q, cd_d;
  logic        dec_q, dec_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [56:1] out_q, out_d;
  logic        sel_q, sel_d;
  logic [3:0]  round_q, round_d;
  logic        busy_q, busy_d;
  logic        fin_q, fin_d;
  logic [3:0]  nxt_idx;

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    dec_d   = dec_q;
    cnt_d   = cnt_q;
    out_d   = '0;
    sel_d   = 1'b0;
    round_d = 4'd0;
    busy_d  = busy_q;
    fin_d   = 1'b0;
    nxt_idx = cnt_q + 4'd1;

    case (state_q)
      StIdle: begin
        if (ks.Key_Schedule_Start) begin
          cd_d    = PC1_BYPASS ? ks.Key_Schedule_Key_Input[56:1]
                               : pc1(ks.Key_Schedule_Key_Input);
          dec_d   = ks.Key_Schedule_Decrypt;
          busy_d  = 1'b1;
          state_d = StLoad;
        end
      end
      StLoad: begin
        cd_d    = rot_cd(cd_q, shift_amt(4'd0, dec_q), dec_q);
        cnt_d   = 4'd0;
        state_d = StRound;
      end
      StRound: begin
        out_d   = cd_q;
        sel_d   = 1'b1;
        round_d = cnt_q;
        // After the last round the rotated value is never presented.
        cd_d    = rot_cd(cd_q, shift_amt(nxt_idx, dec_q), dec_q);
        cnt_d   = nxt_idx;
        if (cnt_q == LastRound) state_d = StDone;
      end
      StDone: begin
        fin_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cd_q    <= '0;
      dec_q   <= 1'b0;
      cnt_q   <= 4'd0;
      out_q   <= '0;
      sel_q   <= 1'b0;
      round_q <= 4'd0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      dec_q   <= dec_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      sel_q   <= sel_d;
      round_q <= round_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
    end
  end

  assign ks.Key_Schedule_Output      = out_q;
  assign ks.Key_Schedule_Select      = sel_q;
  assign ks.Key_Schedule_Round       = round_q;
  assign ks.Key_Schedule_Busy        = busy_q;
  assign ks.Key_Schedule_Finish_Flag = fin_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: known vectors table, random keys against a
// cumulative-rotation reference model, and hand sequences for restart, reset and bypass.
module tb_des_key_schedule;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  des_key_schedule_if u_if ();
  des_key_schedule_if b_if ();

  des_key_schedule #(.PC1_BYPASS(1'b0), .ROUNDS(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .ks  (u_if)
  );

  des_key_schedule #(.PC1_BYPASS(1'b1), .ROUNDS(16)) u_byp (
    .clk (clk),
    .rst (rst),
    .ks  (b_if)
  );

  int n_pass  = 0;
  int n_total = 0;

  int pc1_tab [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  int shifts [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef struct {
    logic [63:0] key;
    bit          dec;
    logic [55:0] first;
    logic [55:0] last;
  } vec_t;
  vec_t vecs [4];

  function automatic logic [27:0] rotl28(input logic [27:0] x, input int s);
    logic [55:0] t;
    t = {28'd0, x} << s;
    return t[27:0] | t[55:28];
  endfunction

  // Output presented at position m: CnDn with n = m+1 (encrypt) or 16-m (decrypt),
  // where Cn is C0 left-rotated by the cumulative shift total of rounds 1..n.
  function automatic logic [55:0] model(input logic [63:0] key, input bit dec, input bit byp,
                                        input int m);
    logic [55:0] cd0;
    int n, s;
    if (byp) cd0 = key[55:0];
    else for (int j = 0; j < 56; j++) cd0[55-j] = key[64-pc1_tab[j]];
    n = dec ? 16 - m : m + 1;
    s = 0;
    for (int i = 0; i < n; i++) s += shifts[i];
    s = s % 28;
    return {rotl28(cd0[55:28], s), rotl28(cd0[27:0], s)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full schedule on u_dut. pre_started: Start was already taken at the previous edge.
  // restart: re-pulse Start with another key/direction at round 5. chain: pulse Start for
  // the next schedule so it is sampled at E19.
  task automatic run_sched(input string tag, input logic [63:0] key, input bit dec,
                           input bit pre_started, input bit restart, input bit chain,
                           input logic [63:0] nkey, input bit ndec,
                           output logic [55:0] first, output logic [55:0] last);
    if (!pre_started) begin
      u_if.Key_Schedule_Key_Input = key;
      u_if.Key_Schedule_Decrypt   = dec;
      u_if.Key_Schedule_Start     = 1'b1;
      tick();
      u_if.Key_Schedule_Start     = 1'b0;
    end
    chk({tag, " busy_e0"}, 64'(u_if.Key_Schedule_Busy), 64'd1);
    chk({tag, " sel_e0"}, 64'(u_if.Key_Schedule_Select), 64'd0);
    tick();
    chk({tag, " sel_e1"}, 64'(u_if.Key_Schedule_Select), 64'd0);
    for (int r = 0; r < 16; r++) begin
      if (restart && r == 5) begin
        u_if.Key_Schedule_Key_Input = key ^ 64'h0123_4567_89AB_CDEF;
        u_if.Key_Schedule_Decrypt   = 1'b1;
        u_if.Key_Schedule_Start     = 1'b1;
      end
      tick();
      u_if.Key_Schedule_Start = 1'b0;
      chk($sformatf("%s sel r%0d", tag, r), 64'(u_if.Key_Schedule_Select), 64'd1);
      chk($sformatf("%s round r%0d", tag, r), 64'(u_if.Key_Schedule_Round), 64'(r));
      chk($sformatf("%s out r%0d", tag, r), 64'(u_if.Key_Schedule_Output),
          64'(model(key, dec, 1'b0, r)));
      chk($sformatf("%s fin r%0d", tag, r), 64'(u_if.Key_Schedule_Finish_Flag), 64'd0);
      if (r == 0)  first = u_if.Key_Schedule_Output;
      if (r == 15) last  = u_if.Key_Schedule_Output;
    end
    tick();
    chk({tag, " fin_e18"}, 64'(u_if.Key_Schedule_Finish_Flag), 64'd1);
    chk({tag, " busy_e18"}, 64'(u_if.Key_Schedule_Busy), 64'd0);
    chk({tag, " sel_e18"}, 64'(u_if.Key_Schedule_Select), 64'd0);
    chk({tag, " out_e18"}, 64'(u_if.Key_Schedule_Output), 64'd0);
    chk({tag, " round_e18"}, 64'(u_if.Key_Schedule_Round), 64'd0);
    if (chain) begin
      u_if.Key_Schedule_Key_Input = nkey;
      u_if.Key_Schedule_Decrypt   = ndec;
      u_if.Key_Schedule_Start     = 1'b1;
    end
    tick();
    u_if.Key_Schedule_Start = 1'b0;
    chk({tag, " fin_e19"}, 64'(u_if.Key_Schedule_Finish_Flag), 64'd0);
  endtask

  initial begin
    logic [55:0] f, l;
    logic [63:0] k, k2;
    bit d, d2;
    int seen;

    vecs[0] = '{64'h133457799BBCDFF1, 1'b0, 56'hE19955FAACCF1E, 56'hF0CCAAF556678F};
    vecs[1] = '{64'h133457799BBCDFF1, 1'b1, 56'hF0CCAAF556678F, 56'hE19955FAACCF1E};
    vecs[2] = '{64'hFFFFFFFFFFFFFFFF, 1'b0, 56'hFFFFFFFFFFFFFF, 56'hFFFFFFFFFFFFFF};
    vecs[3] = '{64'h0000000000000001, 1'b1, 56'h0, 56'h0};

    u_if.Key_Schedule_Key_Input = '0;
    u_if.Key_Schedule_Decrypt   = 1'b0;
    u_if.Key_Schedule_Start     = 1'b0;
    b_if.Key_Schedule_Key_Input = '0;
    b_if.Key_Schedule_Decrypt   = 1'b0;
    b_if.Key_Schedule_Start     = 1'b0;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk("rst out", 64'(u_if.Key_Schedule_Output), 64'd0);
    chk("rst sel", 64'(u_if.Key_Schedule_Select), 64'd0);
    chk("rst round", 64'(u_if.Key_Schedule_Round), 64'd0);
    chk("rst busy", 64'(u_if.Key_Schedule_Busy), 64'd0);
    chk("rst fin", 64'(u_if.Key_Schedule_Finish_Flag), 64'd0);
    chk("rst byp sel", 64'(b_if.Key_Schedule_Select), 64'd0);

    // Known-answer table
    foreach (vecs[i]) begin
      run_sched($sformatf("vec%0d", i), vecs[i].key, vecs[i].dec, 1'b0, 1'b0, 1'b0, '0, 1'b0,
                f, l);
      chk($sformatf("vec%0d first", i), 64'(f), 64'(vecs[i].first));
      chk($sformatf("vec%0d last", i), 64'(l), 64'(vecs[i].last));
    end

    // Random keys against the model
    for (int i = 0; i < 6; i++) begin
      k = {$urandom, $urandom};
      d = 1'($urandom_range(0, 1));
      run_sched($sformatf("rnd%0d", i), k, d, 1'b0, 1'b0, 1'b0, '0, 1'b0, f, l);
    end

    // Start re-pulsed mid-schedule is ignored
    run_sched("restart", 64'h133457799BBCDFF1, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, f, l);

    // Back-to-back: next Start accepted at E19
    k2 = {$urandom, $urandom};
    d2 = 1'b1;
    run_sched("b2b_a", 64'h0E329232EA6D0D73, 1'b0, 1'b0, 1'b0, 1'b1, k2, d2, f, l);
    run_sched("b2b_b", k2, d2, 1'b1, 1'b0, 1'b0, '0, 1'b0, f, l);

    // Reset mid-schedule at round 8
    u_if.Key_Schedule_Key_Input = 64'h133457799BBCDFF1;
    u_if.Key_Schedule_Decrypt   = 1'b0;
    u_if.Key_Schedule_Start     = 1'b1;
    tick();
    u_if.Key_Schedule_Start = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    chk("midrst round8", 64'(u_if.Key_Schedule_Round), 64'd8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst out", 64'(u_if.Key_Schedule_Output), 64'd0);
    chk("midrst sel", 64'(u_if.Key_Schedule_Select), 64'd0);
    chk("midrst busy", 64'(u_if.Key_Schedule_Busy), 64'd0);
    chk("midrst round", 64'(u_if.Key_Schedule_Round), 64'd0);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (u_if.Key_Schedule_Finish_Flag || u_if.Key_Schedule_Select) seen++;
    end
    chk("midrst quiet", 64'(seen), 64'd0);
    run_sched("post_rst", 64'hAABB09182736CCDD, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, f, l);

    // Start and rst together: reset wins
    rst = 1'b1;
    u_if.Key_Schedule_Start = 1'b1;
    tick();
    rst = 1'b0;
    u_if.Key_Schedule_Start = 1'b0;
    chk("rst_start busy", 64'(u_if.Key_Schedule_Busy), 64'd0);
    tick();
    tick();
    chk("rst_start sel", 64'(u_if.Key_Schedule_Select), 64'd0);

    // PC-1 bypass: bits 64:57 ignored, both halves wrap on the first rotate
    b_if.Key_Schedule_Key_Input = 64'hAB80000008000000;
    b_if.Key_Schedule_Decrypt   = 1'b0;
    b_if.Key_Schedule_Start     = 1'b1;
    tick();
    b_if.Key_Schedule_Start = 1'b0;
    tick();
    tick();
    chk("byp r0", 64'(b_if.Key_Schedule_Output), 64'h00000010000001);
    chk("byp r0 model", 64'(b_if.Key_Schedule_Output),
        64'(model(64'hAB80000008000000, 1'b0, 1'b1, 0)));
    for (int c = 0; c < 15; c++) tick();
    chk("byp r15", 64'(b_if.Key_Schedule_Output), 64'h80000008000000);
    tick();
    chk("byp fin", 64'(b_if.Key_Schedule_Finish_Flag), 64'd1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
